// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control path.
// Encodings match the datapath mux and immediate-extractor select wiring.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_RS1   = 2'b10
   } src_a_t;

   typedef enum logic [1:0] {
      SRCB_RS2  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } src_b_t;

   typedef struct packed {
      logic        pc_write;
      logic        adr_src;
      logic        mem_req;
      logic        mem_write;
      logic        ir_write;
      logic        reg_write;
      result_src_t result_src;
      src_a_t      alu_src_a;
      src_b_t      alu_src_b;
      alu_ctrl_t   alu_ctrl;
      imm_src_t    imm_src;
      logic        trap;
   } ctrl_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Only beq (000) and bne (001) are implemented in the branch state.
   function automatic logic is_beq_bne(input logic [2:0] funct3);
      return (funct3[2:1] == 2'b00);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode from funct3/funct7b5; unknown funct3 falls back to add.
module alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_rtype,
   output logic [2:0] alu_ctrl
);

   alu_ctrl_t op_sel;

   always_comb begin
      op_sel = ALU_ADD;
      case (funct3)
         3'b000:  op_sel = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  op_sel = ALU_SLT;
         3'b110:  op_sel = ALU_OR;
         3'b111:  op_sel = ALU_AND;
         default: op_sel = ALU_ADD;
      endcase
   end

   assign alu_ctrl = op_sel;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences one shared ALU and memory port,
// stalls on mem_ready, counts retired instructions and traps on bad opcodes.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter bit TRAP_ILLEGAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             adr_src,
   output logic             mem_req,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_ctrl,
   output logic [1:0]       imm_src,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   state_t     state;
   state_t     state_next;
   logic       retire;
   logic [2:0] alu_dec;
   ctrl_t      ctrl;
   ctrl_t      ctrl_gated;

   alu_decoder u_alu_decoder (
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .is_rtype (op == OP_RTYPE),
      .alu_ctrl (alu_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_next;
   end

   // retire marks every transition into FETCH that completes an instruction.
   always_comb begin
      state_next = state;
      retire     = 1'b0;
      case (state)
         S_FETCH: begin
            if (mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               default: begin
                  if (TRAP_ILLEGAL) begin
                     state_next = S_TRAP;
                  end else begin
                     state_next = S_FETCH;
                     retire     = 1'b1;
                  end
               end
            endcase
         end
         S_MEMADR:   state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: begin
            if (mem_ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_MEMWRITE: begin
            if (mem_ready) begin
               state_next = S_FETCH;
               retire     = 1'b1;
            end
         end
         S_EXECR:    state_next = S_ALUWB;
         S_EXECI:    state_next = S_ALUWB;
         S_ALUWB: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_BRANCH: begin
            if (is_beq_bne(funct3)) begin
               state_next = S_FETCH;
               retire     = 1'b1;
            end else begin
               state_next = S_TRAP;
            end
         end
         S_JAL: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_TRAP:     state_next = S_TRAP;
         default:    state_next = S_FETCH;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req    = 1'b1;
            ctrl.alu_src_a  = SRCA_PC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.alu_ctrl   = ALU_ADD;
            ctrl.result_src = RES_ALURESULT;
            ctrl.ir_write   = mem_ready;
            ctrl.pc_write   = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.imm_src   = IMM_B;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            ctrl.mem_req = 1'b1;
            ctrl.adr_src = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.mem_req   = 1'b1;
            ctrl.adr_src   = 1'b1;
            ctrl.mem_write = mem_ready;
         end
         S_MEMWB: begin
            ctrl.result_src = RES_DATA;
            ctrl.reg_write  = 1'b1;
         end
         S_EXECR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_ctrl  = alu_ctrl_t'(alu_dec);
         end
         S_EXECI: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.imm_src   = IMM_I;
            ctrl.alu_ctrl  = alu_ctrl_t'(alu_dec);
         end
         S_ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a  = SRCA_RS1;
            ctrl.alu_src_b  = SRCB_RS2;
            ctrl.alu_ctrl   = ALU_SUB;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_write   = is_beq_bne(funct3) & (zero ^ funct3[0]);
         end
         S_JAL: begin
            ctrl.alu_src_a  = SRCA_OLDPC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.alu_ctrl   = ALU_ADD;
            ctrl.result_src = RES_ALUOUT;
            ctrl.imm_src    = IMM_J;
            ctrl.pc_write   = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_TRAP: begin
            ctrl.trap = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   // FETCH is the reset state, so its request/enables must be masked while rst_n is low.
   assign ctrl_gated = rst_n ? ctrl : '0;

   assign pc_write   = ctrl_gated.pc_write;
   assign adr_src    = ctrl_gated.adr_src;
   assign mem_req    = ctrl_gated.mem_req;
   assign mem_write  = ctrl_gated.mem_write;
   assign ir_write   = ctrl_gated.ir_write;
   assign reg_write  = ctrl_gated.reg_write;
   assign result_src = ctrl_gated.result_src;
   assign alu_src_a  = ctrl_gated.alu_src_a;
   assign alu_src_b  = ctrl_gated.alu_src_b;
   assign alu_ctrl   = ctrl_gated.alu_ctrl;
   assign imm_src    = ctrl_gated.imm_src;
   assign trap       = ctrl_gated.trap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instret <= '0;
      else if (retire) instret <= instret + CNT_W'(1);
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle sequences built
// from the instruction's rules, driven with random waits and random stimulus.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
   logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0]  alu_ctrl;
   logic        trap;
   logic [31:0] instret;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(32), .TRAP_ILLEGAL(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .adr_src    (adr_src),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .result_src (result_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_ctrl   (alu_ctrl),
      .imm_src    (imm_src),
      .trap       (trap),
      .instret    (instret)
   );

   typedef struct packed {
      logic       pcw, adr, req, mw, irw, rw;
      logic [1:0] rs, sa, sb;
      logic [2:0] ac;
      logic [1:0] is;
      logic       tr;
   } outs_t;

   outs_t       act, exp_o;
   logic [31:0] model_cnt = 0;
   logic        chk_en = 1'b0;
   bit          pin_trap = 0;
   logic [31:0] pin_cnt = 0;
   int          total = 0;
   int          bad = 0;

   assign act = {pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, trap};

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      total = total + 1;
      if (a !== e) begin
         bad = bad + 1;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("outs", {14'b0, act}, {14'b0, exp_o});
         chk("instret", instret, model_cnt);
      end
   end

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   // ALU op the instruction asks for, by mnemonic.
   function automatic logic [2:0] m_alu(input logic [2:0] f3, input logic f7, input logic isr);
      case (f3)
         3'd0:    return (isr && f7) ? 3'b001 : 3'b000;  // sub / add
         3'd2:    return 3'b101;                          // slt
         3'd6:    return 3'b011;                          // or
         3'd7:    return 3'b010;                          // and
         default: return 3'b000;
      endcase
   endfunction

   task automatic step(input logic mr, input logic z, input outs_t e, input logic ret);
      mem_ready = mr;
      zero      = z;
      exp_o     = e;
      chk_en    = 1'b1;
      @(posedge clk);
      if (ret) model_cnt = model_cnt + 1;
      #2;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      exp_o     = '0;
      model_cnt = 0;
      #1;
      chk("rst_async", {14'b0, act}, 32'd0);
      chk("rst_instret", instret, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic trap_hold();
      outs_t e;
      e = '0;
      e.tr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(rb(), rb(), e, 1'b0);
         if (pin_trap) begin
            chk("trap_pin", {31'b0, trap}, 32'd1);
            chk("trap_instret_pin", instret, pin_cnt);
         end
      end
      do_reset();
   endtask

   task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3, input logic f7,
                            input logic z, input int w0, input int w1, input bit abort);
      outs_t e;
      op = op_i; funct3 = f3; funct7b5 = f7;
      // fetch
      e = '0; e.req = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
      for (int i = 0; i < w0; i++) step(1'b0, rb(), e, 1'b0);
      e.irw = 1'b1; e.pcw = 1'b1;
      step(1'b1, rb(), e, 1'b0);
      // decode
      e = '0; e.sa = 2'b01; e.sb = 2'b01; e.is = 2'b10;
      step(rb(), rb(), e, 1'b0);
      case (op_i)
         7'b0000011, 7'b0100011: begin
            e = '0; e.sa = 2'b10; e.sb = 2'b01;
            e.is = (op_i == 7'b0100011) ? 2'b01 : 2'b00;
            step(rb(), rb(), e, 1'b0);
            e = '0; e.req = 1'b1; e.adr = 1'b1;
            for (int i = 0; i < w1; i++) begin
               step(1'b0, rb(), e, 1'b0);
               if (abort) begin
                  do_reset();
                  return;
               end
            end
            if (op_i == 7'b0100011) begin
               e.mw = 1'b1;
               step(1'b1, rb(), e, 1'b1);
            end else begin
               step(1'b1, rb(), e, 1'b0);
               e = '0; e.rs = 2'b01; e.rw = 1'b1;
               step(rb(), rb(), e, 1'b1);
            end
         end
         7'b0110011, 7'b0010011: begin
            e = '0; e.sa = 2'b10;
            if (op_i == 7'b0110011) begin
               e.sb = 2'b00; e.ac = m_alu(f3, f7, 1'b1);
            end else begin
               e.sb = 2'b01; e.is = 2'b00; e.ac = m_alu(f3, f7, 1'b0);
            end
            step(rb(), rb(), e, 1'b0);
            e = '0; e.rw = 1'b1;
            step(rb(), rb(), e, 1'b1);
         end
         7'b1100011: begin
            e = '0; e.sa = 2'b10; e.sb = 2'b00; e.ac = 3'b001;
            if (f3 == 3'd0 || f3 == 3'd1) begin
               e.pcw = (f3 == 3'd0) ? z : !z;
               step(rb(), z, e, 1'b1);
            end else begin
               step(rb(), z, e, 1'b0);
               trap_hold();
            end
         end
         7'b1101111: begin
            e = '0; e.sa = 2'b01; e.sb = 2'b10; e.is = 2'b11; e.pcw = 1'b1; e.rw = 1'b1;
            step(rb(), rb(), e, 1'b1);
         end
         default: trap_hold();
      endcase
   endtask

   task automatic run_hex(input logic [31:0] ins, input logic z, input int w0, input int w1);
      logic [31:0] t;
      t = ins;
      run_instr(t[6:0], t[14:12], t[30], z, w0, w1, 1'b0);
   endtask

   logic [6:0] bad_ops [7] = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h73, 7'h0F, 7'h00};

   initial begin
      int cls;
      rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      exp_o = '0;
      #2;
      chk("rst_outs", {14'b0, act}, 32'd0);
      chk("rst_cnt", instret, 32'd0);
      chk_en = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;

      run_hex(32'h002081B3, 1'b0, 0, 0);
      chk("add_instret", instret, 32'd1);
      run_hex(32'h0040A183, 1'b0, 1, 3);
      chk("lw_instret", instret, 32'd2);
      run_hex(32'h0030A223, 1'b0, 0, 2);
      chk("sw_instret", instret, 32'd3);
      run_hex(32'h00208463, 1'b1, 0, 0);
      run_hex(32'h00208463, 1'b0, 0, 0);
      run_hex(32'h00209463, 1'b1, 0, 0);
      run_hex(32'h00209463, 1'b0, 2, 0);
      chk("br_instret", instret, 32'd7);
      run_hex(32'h008000EF, 1'b0, 0, 0);
      chk("jal_instret", instret, 32'd8);
      pin_trap = 1; pin_cnt = 32'd8;
      run_hex(32'h0000007F, 1'b0, 0, 0);
      pin_trap = 0;
      chk("post_trap_instret", instret, 32'd0);
      run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 2, 1'b1);
      run_hex(32'h002081B3, 1'b0, 0, 0);
      chk("post_abort_instret", instret, 32'd1);

      for (int n = 0; n < 300; n++) begin
         cls = $urandom_range(0, 15);
         case (cls)
            0, 1, 2:  run_instr(7'b0000011, 3'($urandom_range(0, 7)), rb(), rb(),
                                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            3, 4, 5:  run_instr(7'b0100011, 3'($urandom_range(0, 7)), rb(), rb(),
                                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            6, 7, 8:  run_instr(7'b0110011, 3'($urandom_range(0, 7)), rb(), rb(),
                                $urandom_range(0, 3), 0, 1'b0);
            9, 10:    run_instr(7'b0010011, 3'($urandom_range(0, 7)), rb(), rb(),
                                $urandom_range(0, 3), 0, 1'b0);
            11, 12:   run_instr(7'b1100011,
                                ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 7))
                                                            : 3'($urandom_range(0, 1)),
                                rb(), rb(), $urandom_range(0, 3), 0, 1'b0);
            13:       run_instr(7'b1101111, 3'($urandom_range(0, 7)), rb(), rb(),
                                $urandom_range(0, 3), 0, 1'b0);
            14:       run_instr(bad_ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)), rb(), rb(),
                                $urandom_range(0, 3), 0, 1'b0);
            default:  run_instr(7'b0100011, 3'($urandom_range(0, 7)), rb(), rb(),
                                $urandom_range(0, 3), $urandom_range(1, 3), 1'b1);
         endcase
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
